simd_controller: RTL and testbench

- Sequences one SIMD unit through a wavefront's instruction lifecycle: fetch, decode, memory request/wait, execute, register update.
- Drives the shared `simd_state` bus that the PC, fetcher, decoder, register files, ALUs and LSUs key off.
- Steps `curr_wave_cycle` so one decoded instruction is replayed across every LANE_WIDTH-wide slice of the wave.
- Produces the per-cycle active-lane mask and signals wave completion to the wave dispatcher.

---
 rtl/simd_controller_pkg.sv | 23 ++
 rtl/simd_controller_lane_mask_gen.sv | 17 +
 rtl/simd_controller.sv | 102 ++++++++++
 tb/tb_simd_controller.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/simd_controller_pkg.sv
// simd_controller_pkg: shared encodings for the SIMD controller and its consumers
package simd_controller_pkg;
  typedef enum logic [2:0] {
    SIMD_STATE_IDLE    = 3'd0,
    SIMD_STATE_FETCH   = 3'd1,
    SIMD_STATE_DECODE  = 3'd2,
    SIMD_STATE_REQUEST = 3'd3,
    SIMD_STATE_WAIT    = 3'd4,
    SIMD_STATE_EXECUTE = 3'd5,
    SIMD_STATE_UPDATE  = 3'd6,
    SIMD_STATE_DONE    = 3'd7
  } simd_state_e;
  typedef enum logic [1:0] {
    LSU_STATE_IDLE       = 2'd0,
    LSU_STATE_REQUESTING = 2'd1,
    LSU_STATE_WAITING    = 2'd2,
    LSU_STATE_DONE       = 2'd3
  } lsu_state_e;
  localparam logic [2:0] FETCHER_FETCHED = 3'd2;
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
endpackage

// File: rtl/simd_controller_lane_mask_gen.sv
// simd_controller_lane_mask_gen: active-lane mask for one slice of a wave
module simd_controller_lane_mask_gen #(
  parameter int LANE_WIDTH = 16,
  parameter int CYC_W = 1,
  parameter int THR_W = 6
) (
  input  logic [CYC_W-1:0]      cyc_i,
  input  logic [THR_W-1:0]      threads_i,
  output logic [LANE_WIDTH-1:0] mask_o
);
  // lane i is live when its global thread index falls below the thread count
  always_comb begin
    mask_o = '0;
    for (int i = 0; i < LANE_WIDTH; i++)
      mask_o[i] = (32'(cyc_i) * 32'(LANE_WIDTH) + 32'(i)) < 32'(threads_i);
  end
endmodule

// File: rtl/simd_controller.sv
// simd_controller: sequences a SIMD unit through fetch/decode/memory/execute/update per wave slice
module simd_controller
  import simd_controller_pkg::*;
#(
  parameter int LANE_WIDTH = 16,
  parameter int WAVE_SIZE = 32,
  localparam int TOTAL_WAVE_CYCLES = ceil_div(WAVE_SIZE, LANE_WIDTH),
  localparam int CYC_W = (TOTAL_WAVE_CYCLES > 1) ? $clog2(TOTAL_WAVE_CYCLES) : 1,
  localparam int THR_W = $clog2(WAVE_SIZE + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    simd_start,
  input  logic [THR_W-1:0]        active_threads,
  input  logic [2:0]              fetcher_state,
  input  logic                    MEM_READ,
  input  logic                    MEM_WRITE,
  input  logic                    RET,
  input  logic [2*LANE_WIDTH-1:0] lsu_state,
  output logic [2:0]              simd_state,
  output logic [CYC_W-1:0]        curr_wave_cycle,
  output logic [LANE_WIDTH-1:0]   lane_mask,
  output logic                    simd_done
);
  simd_state_e      state_q;
  logic [CYC_W-1:0] cyc_q;
  logic [THR_W-1:0] thr_q;
  logic             done_q;
  logic             lanes_done;
  logic             wait_done;
  logic [31:0]      nxt_slice;
  logic             has_next;

  simd_controller_lane_mask_gen #(
    .LANE_WIDTH(LANE_WIDTH),
    .CYC_W(CYC_W),
    .THR_W(THR_W)
  ) u_mask (
    .cyc_i(cyc_q),
    .threads_i(thr_q),
    .mask_o(lane_mask)
  );

  // memory wait ends once every live lane's LSU reports done; dead lanes never block
  always_comb begin
    lanes_done = 1'b1;
    for (int i = 0; i < LANE_WIDTH; i++)
      if (lane_mask[i] && lsu_state[2*i+:2] != LSU_STATE_DONE) lanes_done = 1'b0;
  end

  assign wait_done = !(MEM_READ || MEM_WRITE) || lanes_done;
  assign nxt_slice = 32'(cyc_q) + 32'd1;
  assign has_next  = (nxt_slice < 32'(TOTAL_WAVE_CYCLES)) &&
                     (nxt_slice * 32'(LANE_WIDTH) < 32'(thr_q));

  // lifecycle FSM: one decoded instruction replays across every live slice before refetch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SIMD_STATE_IDLE;
      cyc_q   <= '0;
      thr_q   <= '0;
      done_q  <= 1'b0;
    end else if (enable) begin
      case (state_q)
        SIMD_STATE_IDLE, SIMD_STATE_DONE:
          if (simd_start) begin
            state_q <= SIMD_STATE_FETCH;
            thr_q   <= active_threads;
            cyc_q   <= '0;
            done_q  <= 1'b0;
          end
        SIMD_STATE_FETCH:   if (fetcher_state == FETCHER_FETCHED) state_q <= SIMD_STATE_DECODE;
        SIMD_STATE_DECODE:  state_q <= SIMD_STATE_REQUEST;
        SIMD_STATE_REQUEST: state_q <= SIMD_STATE_WAIT;
        SIMD_STATE_WAIT:    if (wait_done) state_q <= SIMD_STATE_EXECUTE;
        SIMD_STATE_EXECUTE: state_q <= SIMD_STATE_UPDATE;
        SIMD_STATE_UPDATE:
          if (has_next) begin
            cyc_q   <= cyc_q + CYC_W'(1);
            state_q <= SIMD_STATE_REQUEST;
          end else if (RET) begin
            state_q <= SIMD_STATE_DONE;
            done_q  <= 1'b1;
          end else begin
            cyc_q   <= '0;
            state_q <= SIMD_STATE_FETCH;
          end
        default: state_q <= SIMD_STATE_IDLE;
      endcase
    end
  end

  assign simd_state      = state_q;
  assign curr_wave_cycle = cyc_q;
  assign simd_done       = done_q;

  // a dispatched wave must carry at least one thread
  a_nonzero_threads: assert property (@(posedge clk) disable iff (rst)
    (enable && simd_start && (state_q == SIMD_STATE_IDLE || state_q == SIMD_STATE_DONE))
      |-> (active_threads != '0));
endmodule

// File: tb/tb_simd_controller.sv
// tb_simd_controller: directed lifecycle traces checked every cycle against an instruction-level model
module tb_simd_controller;
  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_REQUEST = 3;
  localparam int S_WAIT = 4, S_EXECUTE = 5, S_UPDATE = 6, S_DONE = 7;

  logic        clk = 0, rst = 1, enable = 1, simd_start = 0;
  logic        MEM_READ = 0, MEM_WRITE = 0, RET = 0;
  logic [5:0]  active_threads = 6'd32;
  logic [2:0]  fetcher_state = 3'd0;
  logic [31:0] lsu_state = 32'd0;
  logic [2:0]  simd_state;
  logic [0:0]  curr_wave_cycle;
  logic [15:0] lane_mask;
  logic        simd_done;

  int checks = 0, failures = 0;
  bit chk_en = 0;
  int exp_st = S_IDLE, exp_cyc = 0, exp_thr = 0;
  bit exp_done = 0;

  always #5 clk = ~clk;

  simd_controller dut (
    .clk(clk), .rst(rst), .enable(enable), .simd_start(simd_start),
    .active_threads(active_threads), .fetcher_state(fetcher_state),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .RET(RET), .lsu_state(lsu_state),
    .simd_state(simd_state), .curr_wave_cycle(curr_wave_cycle),
    .lane_mask(lane_mask), .simd_done(simd_done)
  );

  function automatic logic [15:0] mask_of(input int cyc, input int thr);
    logic [15:0] m;
    for (int i = 0; i < 16; i++) m[i] = (cyc * 16 + i) < thr;
    return m;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    check("state", int'(simd_state), exp_st);
    check("cycle", int'(curr_wave_cycle), exp_cyc);
    check("mask", int'(lane_mask), int'(mask_of(exp_cyc, exp_thr)));
    check("done", int'(simd_done), int'(exp_done));
  end

  task automatic go(input int st, input int cyc, input bit done);
    @(posedge clk);
    #1;
    exp_st = st;
    exp_cyc = cyc;
    exp_done = done;
  endtask

  task automatic start_wave(input int thr);
    active_threads = 6'(thr);
    simd_start = 1;
    go(S_FETCH, 0, 0);
    exp_thr = thr;
    simd_start = 0;
  endtask

  task automatic run_instr(input int fetch_n, input bit rd, input bit wr, input int w0,
                           input int w1, input bit ret, input bit spur, input bit frz, input bit rst1);
    int n;
    n = (exp_thr + 15) / 16;
    if (n > 2) n = 2;
    fetcher_state = 3'd0;
    repeat (fetch_n - 1) go(S_FETCH, 0, 0);
    fetcher_state = 3'd2;
    go(S_DECODE, 0, 0);
    fetcher_state = 3'd0;
    MEM_READ = rd;
    MEM_WRITE = wr;
    RET = ret;
    for (int s = 0; s < n; s++) begin
      int w;
      logic [15:0] m;
      logic [31:0] dn;
      w = (s == 0) ? w0 : w1;
      m = mask_of(s, exp_thr);
      dn = '0;
      for (int i = 0; i < 16; i++) if (m[i]) dn[2*i+:2] = 2'd3;
      go(S_REQUEST, s, 0);
      lsu_state = '0;
      go(S_WAIT, s, 0);
      if (frz && s == n - 1) begin
        enable = 0;
        lsu_state = dn;
        repeat (3) go(S_WAIT, s, 0);
        lsu_state = '0;
        enable = 1;
      end
      for (int k = 1; k < w; k++) begin
        if (spur && s == 0 && k == 1) begin
          simd_start = 1;
          active_threads = 6'd5;
        end
        go(S_WAIT, s, 0);
        simd_start = 0;
        active_threads = 6'(exp_thr);
      end
      lsu_state = dn;
      go(S_EXECUTE, s, 0);
      lsu_state = '0;
      if (rst1 && s == n - 1) begin
        rst = 1;
        go(S_IDLE, 0, 0);
        exp_thr = 0;
        rst = 0;
        MEM_READ = 0;
        MEM_WRITE = 0;
        RET = 0;
        return;
      end
      go(S_UPDATE, s, 0);
    end
    MEM_READ = 0;
    MEM_WRITE = 0;
    if (ret) go(S_DONE, n - 1, 1);
    else go(S_FETCH, 0, 0);
    RET = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    check("pin_m32", int'(mask_of(0, 32)), 'hFFFF);
    check("pin_m20", int'(mask_of(1, 20)), 'h000F);
    check("pin_m10", int'(mask_of(0, 10)), 'h03FF);
    check("pin_m17", int'(mask_of(1, 17)), 'h0001);
    go(S_IDLE, 0, 0);
    chk_en = 1;
    go(S_IDLE, 0, 0);
    rst = 0;
    go(S_IDLE, 0, 0);
    go(S_IDLE, 0, 0);
    start_wave(32);
    run_instr(2, 0, 0, 1, 1, 0, 0, 0, 0);
    run_instr(1, 0, 0, 1, 1, 1, 0, 0, 0);
    go(S_DONE, 1, 1);
    start_wave(20);
    run_instr(1, 1, 0, 3, 4, 0, 1, 1, 0);
    run_instr(3, 0, 0, 1, 1, 1, 0, 0, 0);
    start_wave(10);
    run_instr(1, 0, 0, 1, 1, 1, 0, 0, 0);
    check("lit_mask10", int'(lane_mask), 'h03FF);
    check("lit_done10", int'(simd_done), 1);
    go(S_DONE, 0, 1);
    go(S_DONE, 0, 1);
    start_wave(32);
    run_instr(1, 0, 1, 2, 2, 0, 0, 0, 1);
    go(S_IDLE, 0, 0);
    start_wave(17);
    run_instr(1, 1, 0, 1, 2, 1, 0, 0, 0);
    start_wave(16);
    run_instr(2, 0, 0, 1, 1, 1, 0, 0, 0);
    go(S_DONE, 0, 1);
    @(posedge clk);
    #1;
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
